// File: rtl/fp_pkg.sv
// Shared FSM encoding and width helpers for the fixed-point accumulate/round/saturate stages.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int NB_IN_DEF   = 9;
  localparam int NBF_IN_DEF  = 8;
  localparam int LOG2_N_DEF  = 3;
  localparam int NB_OUT_DEF  = 9;
  localparam int NBF_OUT_DEF = 6;

  localparam int NB_ACC  = NB_IN_DEF + LOG2_N_DEF;
  localparam int NB_DROP = NBF_IN_DEF - NBF_OUT_DEF;

  // Summing 2^log2_n samples grows the magnitude by at most log2_n bits.
  function automatic int acc_width(input int nb_in, input int log2_n);
    return nb_in + log2_n;
  endfunction

  function automatic int drop_width(input int nbf_in, input int nbf_out);
    return nbf_in - nbf_out;
  endfunction

endpackage

// File: rtl/fp_round_sat.sv
// Combinational round-half-up and saturate from a wide signed value to S(NB_OUT, *).
module fp_round_sat #(
  parameter int NB_ACC  = 12,
  parameter int NB_DROP = 2,
  parameter int NB_OUT  = 9
) (
  input  logic signed [NB_ACC-1:0] acc,
  output logic        [NB_OUT-1:0] value,
  output logic                     sat
);

  localparam int NB_RND = NB_ACC + 1 - NB_DROP;
  localparam logic signed [NB_ACC:0] HALF = (NB_ACC + 1)'(1) << (NB_DROP - 1);

  logic signed [NB_ACC:0]   biased;
  logic signed [NB_RND-1:0] rounded;

  // One extra bit keeps the half-LSB bias from overflowing at the positive limit.
  always_comb begin
    biased  = $signed({acc[NB_ACC-1], acc}) + HALF;
    rounded = NB_RND'(biased >>> NB_DROP);
  end

  generate
    if (NB_RND > NB_OUT) begin : g_clamp
      localparam logic signed [NB_RND-1:0] MAX_V = NB_RND'((1 << (NB_OUT - 1)) - 1);
      localparam logic signed [NB_RND-1:0] MIN_V = ~MAX_V;

      always_comb begin
        value = rounded[NB_OUT-1:0];
        sat   = 1'b0;
        if (rounded > MAX_V) begin
          value = {1'b0, {(NB_OUT - 1){1'b1}}};
          sat   = 1'b1;
        end else if (rounded < MIN_V) begin
          value = {1'b1, {(NB_OUT - 1){1'b0}}};
          sat   = 1'b1;
        end
      end
    end else begin : g_fits
      always_comb begin
        value = NB_OUT'(rounded);
        sat   = 1'b0;
      end
    end
  endgenerate

endmodule

// File: rtl/fp_accum_sat.sv
// Block accumulator: sums 2^LOG2_N samples, then rounds and saturates the block sum.
// Optional o_sat flag output is enabled by defining FP_ACCUM_SAT_FLAG_EN.
module fp_accum_sat
  import fp_pkg::*;
#(
  parameter int NB_IN   = NB_IN_DEF,
  parameter int NBF_IN  = NBF_IN_DEF,
  parameter int LOG2_N  = LOG2_N_DEF,
  parameter int NB_OUT  = NB_OUT_DEF,
  parameter int NBF_OUT = NBF_OUT_DEF
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic [NB_IN-1:0]  i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [NB_OUT-1:0] o_data,
  output logic              o_valid,
`ifdef FP_ACCUM_SAT_FLAG_EN
  output logic              o_sat,
`endif
  input  logic              i_ready
);

  localparam int ACC_W  = acc_width(NB_IN, LOG2_N);
  localparam int DROP_W = drop_width(NBF_IN, NBF_OUT);
  localparam logic [LOG2_N-1:0] LAST = '1;

  state_t                    state, state_next;
  logic signed [ACC_W-1:0]   acc, acc_next, sample, sum;
  logic        [LOG2_N-1:0]  count, count_next;
  logic                      accept, load_out;
  logic        [NB_OUT-1:0]  rs_value;
  logic                      rs_sat;

  assign o_ready = (state != HOLD);
  assign o_valid = (state == HOLD);
  assign accept  = i_valid && o_ready && !i_clear;
  assign sample  = ACC_W'($signed(i_data));
  assign sum     = acc + sample;

  fp_round_sat #(
    .NB_ACC  (ACC_W),
    .NB_DROP (DROP_W),
    .NB_OUT  (NB_OUT)
  ) u_round_sat (
    .acc   (sum),
    .value (rs_value),
    .sat   (rs_sat)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      count <= count_next;
    end
  end

  // The rounder sees acc + current sample, so the final sum is captured on the Nth accept.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    count_next = count;
    load_out   = 1'b0;
    if (i_clear) begin
      state_next = IDLE;
      acc_next   = '0;
      count_next = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state_next = ACC;
            acc_next   = sample;
            count_next = LOG2_N'(1);
          end
        end
        ACC: begin
          if (accept) begin
            if (count == LAST) begin
              state_next = HOLD;
              acc_next   = '0;
              count_next = '0;
              load_out   = 1'b1;
            end else begin
              acc_next   = sum;
              count_next = count + LOG2_N'(1);
            end
          end
        end
        HOLD: begin
          if (i_ready) state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
          acc_next   = '0;
          count_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) o_data <= '0;
    else if (load_out) o_data <= rs_value;
  end

`ifdef FP_ACCUM_SAT_FLAG_EN
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) o_sat <= 1'b0;
    else if (load_out) o_sat <= rs_sat;
  end
`else
  logic unused_sat;
  assign unused_sat = rs_sat;
`endif

endmodule

// File: tb/tb_fp_accum_sat.sv
// Scoreboard bench for fp_accum_sat: directed corner cases plus randomized blocks.
module tb_fp_accum_sat;

  localparam int N      = 8;
  localparam int DROP   = 2;
  localparam int NB_OUT = 9;

  typedef struct {
    logic [8:0] data;
    logic       sat;
  } exp_t;

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_clear = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_ready;
  logic [8:0] i_data = '0;
  logic       o_ready, o_valid;
  logic [8:0] o_data;
`ifdef FP_ACCUM_SAT_FLAG_EN
  logic       o_sat;
`endif

  exp_t       exp_q[$];
  int         blk[$];
  int         n_checks = 0;
  int         n_fails = 0;
  int         ready_mode = 0;
  logic       held = 1'b0;
  logic [8:0] held_data;
  exp_t       e;

  fp_accum_sat dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_clear),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
`ifdef FP_ACCUM_SAT_FLAG_EN
    .o_sat   (o_sat),
`endif
    .i_ready (i_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: exact integer sum, round half-up in real units of 2^-6, clamp to S(9,6).
  function automatic exp_t block_result(input int s[$]);
    exp_t r;
    int   sum = 0;
    int   q;
    int   hi = (1 << (NB_OUT - 1)) - 1;
    int   lo = -(1 << (NB_OUT - 1));
    foreach (s[i]) sum += s[i];
    q = (sum + (1 << (DROP - 1))) >>> DROP;
    r.sat = (q > hi) || (q < lo);
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    r.data = 9'(q);
    return r;
  endfunction

  task automatic model_accept(input logic [8:0] d);
    blk.push_back(int'($signed(d)));
    if (blk.size() == N) begin
      exp_q.push_back(block_result(blk));
      blk.delete();
    end
  endtask

  // Entry and exit at posedge+1; waits on o_ready with a bounded budget.
  task automatic send_sample(input logic [8:0] d, input int gap);
    i_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    i_valid = 1'b1;
    i_data  = d;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (o_ready) begin
        @(posedge clk);
        model_accept(d);
        #1;
        i_valid = 1'b0;
        return;
      end
    end
    n_checks++;
    n_fails++;
    $display("[TB] FAIL accept_timeout: o_ready=%0b, required 1 within 200 cycles", o_ready);
    i_valid = 1'b0;
  endtask

  task automatic send_block(input logic [8:0] d, input int cnt);
    for (int k = 0; k < cnt; k++) send_sample(d, 0);
  endtask

  task automatic clear_pulse();
    i_clear = 1'b1;
    i_valid = 1'b1;
    i_data  = 9'($urandom);
    @(posedge clk);
    blk.delete();
    #1;
    i_clear = 1'b0;
    i_valid = 1'b0;
    check("clear_valid", o_valid, 0);
    check("clear_ready", o_ready, 1);
  endtask

  task automatic reset_pulse();
    i_valid = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    blk.delete();
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 1);
    check("rst_data", o_data, 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: i_ready = 1'b1;
        1: i_ready = 1'($urandom_range(0, 1));
        default: i_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops one expectation per output handshake and checks stability under backpressure.
  initial begin
    forever begin
      @(negedge clk);
      if (o_valid) begin
        check("hold_ready_low", o_ready, 0);
        if (held) check("hold_stable", o_data, held_data);
        if (i_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL unexpected_output: got 0x%0h, required no output", o_data);
          end else begin
            e = exp_q.pop_front();
            check("block_data", o_data, e.data);
`ifdef FP_ACCUM_SAT_FLAG_EN
            check("block_sat", o_sat, e.sat);
`endif
          end
          held = 1'b0;
        end else begin
          held      = 1'b1;
          held_data = o_data;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #3;
    check("init_valid", o_valid, 0);
    check("init_ready", o_ready, 1);
    check("init_data", o_data, 0);
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Nominal block with downstream stalled, then backpressure with i_valid held high.
    ready_mode = 2;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    send_block(9'h040, N - 1);
    check("latency_early", o_valid, 0);
    send_sample(9'h040, 0);
    check("latency_valid", o_valid, 1);
    check("latency_ready", o_ready, 0);
    check("nominal_data", o_data, 9'h080);
    i_valid = 1'b1;
    i_data  = 9'h0FF;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_ready", o_ready, 0);
      check("bp_data", o_data, 9'h080);
    end
    i_valid    = 1'b0;
    ready_mode = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      #1;
      if (o_ready) break;
    end
    check("bp_release", o_ready, 1);

    send_block(9'h040, 3);
    reset_pulse();
    send_block(9'h040, N);

    send_block(9'h0FF, N);
    send_block(9'h100, N);

    send_sample(9'h002, 0);
    send_block(9'h000, N - 1);
    send_sample(9'h001, 0);
    send_block(9'h000, N - 1);
    send_sample(9'h1FE, 0);
    send_block(9'h000, N - 1);

    send_block(9'h040, 3);
    clear_pulse();
    send_block(9'h020, N);

    ready_mode = 1;
    for (int k = 0; k < 320; k++) begin
      logic [8:0] d;
      if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 1) ? 9'h0FF : 9'h100;
      else d = 9'($urandom_range(0, 511));
      if (blk.size() > 0 && $urandom_range(0, 19) == 0) clear_pulse();
      send_sample(d, $urandom_range(0, 2));
    end

    ready_mode = 0;
    for (int t = 0; t < 100 && exp_q.size() > 0; t++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
